// File: rtl/bit_permute_pkg.sv
// Shared encodings for the bit permute unit: operation modes and FSM states.
package bit_permute_pkg;

  localparam logic [1:0] MODE_REV   = 2'b00;
  localparam logic [1:0] MODE_ROL   = 2'b01;
  localparam logic [1:0] MODE_ROR   = 2'b10;
  localparam logic [1:0] MODE_BSWAP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/bit_reverse_n.sv
// Combinational WIDTH-bit reverse: y[i] = a[WIDTH-1-i].
module bit_reverse_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign y[i] = a[WIDTH-1-i];
  end

endmodule

// File: rtl/bit_permute_unit.sv
// Multi-cycle bit reverse / rotate / byte-swap engine with valid/ready on both sides.
// Build option BIT_PERMUTE_FAST_ROTATE_EN: single-cycle barrel rotate, RUN never entered.
module bit_permute_unit
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // One extra bit so STEP == WIDTH is representable.
  localparam logic [AMT_W:0] STEP_L = (AMT_W+1)'(STEP);

  state_e           state_r, state_nx_s;
  logic [WIDTH-1:0] work_r, work_nx_s;
  logic [AMT_W-1:0] rem_r, rem_nx_s;
  logic [1:0]       mode_r, mode_nx_s;
  logic [WIDTH-1:0] out_data_r, res_nx_s;
  logic             out_valid_r, in_ready_r, out_zero_r;
  logic [WIDTH-1:0] rev_s, step_rot_s;
  logic [AMT_W:0]   rem_ext_s, step_s;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input logic [AMT_W:0] a);
    logic [2*WIDTH-1:0] d;
    d = {x, x} << a;
    return d[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input logic [AMT_W:0] a);
    logic [2*WIDTH-1:0] d;
    d = {x, x} >> a;
    return d[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] bswap(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int k = 0; k < WIDTH/8; k++) begin
      r[8*(WIDTH/8-1-k) +: 8] = x[8*k +: 8];
    end
    return r;
  endfunction

  bit_reverse_n #(.WIDTH(WIDTH)) u_rev (
    .a (in_data),
    .y (rev_s)
  );

  // Rotate amount for this RUN cycle: min(STEP, remaining).
  always_comb begin
    rem_ext_s = {1'b0, rem_r};
    if (rem_ext_s < STEP_L) begin
      step_s = rem_ext_s;
    end else begin
      step_s = STEP_L;
    end
    if (mode_r == MODE_ROR) begin
      step_rot_s = rotr(work_r, step_s);
    end else begin
      step_rot_s = rotl(work_r, step_s);
    end
  end

  // Next-state and datapath decisions; result only changes on entry to DONE.
  always_comb begin
    state_nx_s = state_r;
    work_nx_s  = work_r;
    rem_nx_s   = rem_r;
    mode_nx_s  = mode_r;
    res_nx_s   = out_data_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          mode_nx_s  = in_mode;
          work_nx_s  = in_data;
          rem_nx_s   = in_amt;
          state_nx_s = ST_DONE;
          case (in_mode)
            MODE_REV:   res_nx_s = rev_s;
            MODE_BSWAP: res_nx_s = bswap(in_data);
            MODE_ROL, MODE_ROR: begin
`ifdef BIT_PERMUTE_FAST_ROTATE_EN
              if (in_mode == MODE_ROL) begin
                res_nx_s = rotl(in_data, {1'b0, in_amt});
              end else begin
                res_nx_s = rotr(in_data, {1'b0, in_amt});
              end
`else
              if (in_amt == {AMT_W{1'b0}}) begin
                res_nx_s = in_data;
              end else begin
                state_nx_s = ST_RUN;
              end
`endif
            end
            default: res_nx_s = in_data;
          endcase
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        work_nx_s = step_rot_s;
        rem_nx_s  = rem_r - step_s[AMT_W-1:0];
        if (rem_r == step_s[AMT_W-1:0]) begin
          state_nx_s = ST_DONE;
          res_nx_s   = step_rot_s;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      work_r      <= {WIDTH{1'b0}};
      rem_r       <= {AMT_W{1'b0}};
      mode_r      <= MODE_REV;
      out_data_r  <= {WIDTH{1'b0}};
      out_zero_r  <= 1'b1;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx_s;
      work_r      <= work_nx_s;
      rem_r       <= rem_nx_s;
      mode_r      <= mode_nx_s;
      out_data_r  <= res_nx_s;
      out_zero_r  <= (res_nx_s == {WIDTH{1'b0}});
      out_valid_r <= (state_nx_s == ST_DONE);
      in_ready_r  <= (state_nx_s == ST_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_zero  = out_zero_r;

endmodule

// File: tb/tb_bit_permute_unit.sv
// Scoreboard bench for bit_permute_unit (WIDTH=16, STEP=1) with directed vectors.
module tb_bit_permute_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic [1:0]  in_mode = 2'b00;
  logic [3:0]  in_amt = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_zero;

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] sb_q[$];

  bit_permute_unit #(.WIDTH(16), .STEP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] m, input logic [3:0] a);
`ifdef BIT_PERMUTE_FAST_ROTATE_EN
    return 1;
`else
    if ((m == 2'b01 || m == 2'b10) && a != 4'd0) return int'(a) + 1;
    return 1;
`endif
  endfunction

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", {15'd0, out_zero, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [16:0] e;
        e = sb_q.pop_front();
        check("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
        check("out_zero", {31'd0, out_zero}, {31'd0, e[16]});
      end
    end
  end

  // Issue one request; optionally wait for and time its out_valid.
  task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [3:0] a,
                      input logic [15:0] exp, input bit wait_done);
    int waited = 0;
    int lat = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1; in_data = d; in_mode = m; in_amt = a;
    sb_q.push_back({(exp == 16'h0000), exp});
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (wait_done) begin
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 200);
      check("latency", lat, exp_lat(m, a));
    end
  endtask

  initial begin
    logic [15:0] held;
    int w;
    // Reset state
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    send(16'h0001, 2'b00, 4'd0,  16'h8000, 1'b1);
    send(16'h8001, 2'b01, 4'd4,  16'h0018, 1'b1);
    send(16'h0001, 2'b10, 4'd15, 16'h0002, 1'b1);
    send(16'h12AB, 2'b11, 4'd0,  16'hAB12, 1'b1);
    send(16'h0000, 2'b01, 4'd3,  16'h0000, 1'b1);
    send(16'h1234, 2'b01, 4'd0,  16'h1234, 1'b1);
    send(16'h00F1, 2'b10, 4'd4,  16'h100F, 1'b1);
    send(16'h1234, 2'b00, 4'd7,  16'h2C48, 1'b1);
    send(16'hA5C3, 2'b01, 4'd8,  16'hC3A5, 1'b1);

    // Back-pressure: hold DONE, keep a new request pending.
    @(posedge clk); #1 out_ready = 1'b0;
    send(16'h00FF, 2'b11, 4'd0, 16'hFF00, 1'b1);
    held = out_data;
    #1 in_valid = 1'b1; in_data = 16'h0003; in_mode = 2'b10; in_amt = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", {16'd0, out_data}, {16'd0, 16'hFF00});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    check("bp_held", {16'd0, held}, {16'd0, 16'hFF00});
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_idle_out_data", {16'd0, out_data}, {16'd0, 16'hFF00});
    sb_q.push_back({1'b0, 16'h8001});
    @(posedge clk); #1 in_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 200);
    check("bp_pending_latency", w, exp_lat(2'b10, 4'd1));

    // Abort on cycle 3 of an amt=8 rotate.
    send(16'h00FF, 2'b01, 4'd8, 16'hFF00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
`ifndef BIT_PERMUTE_FAST_ROTATE_EN
    check("abort_not_done", {31'd0, out_valid}, 32'd0);
`endif
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_data", {16'd0, out_data}, 32'd0);
    check("abort_out_zero", {31'd0, out_zero}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(16'h00FF, 2'b01, 4'd8, 16'hFF00, 1'b1);

    // Drain scoreboard.
    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", sb_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
